uart_cmd_decoder: RTL and testbench
===================================

UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

Interface
REQ-001 SHALL have parameter COOLDOWN_CYCLES, default 2700000, meaning cycles after an accepted action during which new commands are dropped; legal range 1 to 2^24-1.
REQ-002 SHALL have one clock and an asynchronous, active-low reset: `clk` and `rst_n`.
REQ-003 clk  input  1  system clock, 27 MHz.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 rx_byte  input  8  received byte from the UART receiver; 0x00 = no byte; a nonzero value is held until the next start bit.
REQ-006 is_sleeping  input  1  pet asleep; while high, only WAKE is accepted.
REQ-007 act_ready  input  1  pet core accepts the action.
REQ-008 act_valid  output  1  action pending.
REQ-009 act_code  output  3  action: 1 FEED, 2 PLAY, 3 CLEAN, 4 SLEEP, 5 WAKE; 0 when act_valid is low.
REQ-010 busy  output  1  high in EMIT or COOLDOWN.
REQ-011 err_pulse  output  1  one-cycle error strobe.
REQ-012 err_count  output  8  saturating error count.

Function
REQ-013 Byte event SHALL be defined as rx_byte != 0 while register rx_nz_q == 0; rx_nz_q <= (rx_byte != 0) every cycle, so each received byte yields exactly one event, including repeated identical bytes.
REQ-014 Command letters SHALL be 'F'/'f'=1, 'P'/'p'=2, 'C'/'c'=3, 'S'/'s'=4, 'W'/'w'=5; terminators CR (0x0D) and LF (0x0A); cancel BS (0x08) and DEL (0x7F); every other nonzero byte is "other".
REQ-015 The FSM SHALL have states IDLE, GOT_CMD, EMIT and COOLDOWN, and SHALL react to an event at the same clock edge on which the event condition is true.
REQ-016 IDLE: letter -> latch code, go to GOT_CMD; CR, LF, space, BS or DEL -> ignored; other -> error.
REQ-017 GOT_CMD: letter -> replace latched code (last wins) and stay; BS or DEL -> clear code, go to IDLE, no error; other -> error, go to IDLE.
REQ-018 GOT_CMD terminator: if is_sleeping=1 and code != 5 -> error, go to IDLE; otherwise go to EMIT.
REQ-019 EMIT: act_valid=1 and act_code=latched code, both stable until the cycle act_ready=1; that cycle is the handshake; next state is COOLDOWN with the counter loaded to COOLDOWN_CYCLES.
REQ-020 act_valid SHALL rise the cycle after the terminator event and SHALL drop the cycle after the handshake.
REQ-021 COOLDOWN: counter decrements each cycle; when the counter equals 1, next state is IDLE, so the block is busy for exactly COOLDOWN_CYCLES cycles after the handshake.
REQ-022 In EMIT and COOLDOWN: CR and LF are ignored silently; any other event is dropped and counts as an error.
REQ-023 Error: err_pulse=1 for the cycle after the offending event; err_count increments and saturates at 255; simultaneous errors are impossible (one event per cycle).
REQ-024 is_sleeping is sampled only at the terminator event; changes during EMIT SHALL NOT retract the action.
REQ-025 busy SHALL equal (state == EMIT or state == COOLDOWN), registered.

Reset
REQ-026 rst_n low SHALL asynchronously force: state IDLE, latched code 0, counter 0, act_valid 0, act_code 0, busy 0, err_pulse 0, err_count 0, rx_nz_q 1.
REQ-027 Because rx_nz_q resets to 1, a byte held on rx_byte across reset release SHALL NOT generate an event.
REQ-028 Reset asserted mid-EMIT or mid-COOLDOWN SHALL abort the action with no handshake and no error.

Verification (COOLDOWN_CYCLES=8)
REQ-029 'f' then CR, act_ready=1 -> act_valid high 1 cycle with act_code=1; busy high 9 cycles total; err_count=0.
REQ-030 'p', 'c', LF with act_ready held 0 for 5 cycles -> act_code=3 held stable 5 cycles; the later LF in EMIT causes no error.
REQ-031 is_sleeping=1, 's' CR -> no act_valid, err_pulse once, err_count=1; then 'w' CR -> act_code=5.
REQ-032 'x' in IDLE -> err_count=1; 'f', BS, CR -> no action, no error; 'f' during COOLDOWN -> err_count increments, no action.
REQ-033 300 'x' bytes -> err_count saturates at 255.
REQ-034 rst_n low during EMIT with rx_byte='f' held through release -> all outputs 0, and no event until rx_byte returns to 0 and a new byte arrives.

Source files
------------

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: turns single-letter UART commands into pet-core actions,
// with terminator/cancel handling, a post-action cooldown and a saturating error counter.
`default_nettype none

module uart_cmd_decoder #(
  parameter int unsigned COOLDOWN_CYCLES = 2700000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_byte,
  input  logic       is_sleeping,
  input  logic       act_ready,
  output logic       act_valid,
  output logic [2:0] act_code,
  output logic       busy,
  output logic       err_pulse,
  output logic [7:0] err_count
);

  localparam logic [23:0] CD_LOAD  = 24'(COOLDOWN_CYCLES);
  localparam logic [2:0]  CODE_WAKE = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_GOT_CMD  = 2'd1,
    S_EMIT     = 2'd2,
    S_COOLDOWN = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  code_q, code_d;
  logic [23:0] cnt_q, cnt_d;
  logic        rx_nz_q;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  logic       ev;
  logic [2:0] letter;
  logic       is_letter, is_term, is_cancel, is_space;

  // rx_nz_q resets high so a byte held across reset release is not an event.
  assign ev = (rx_byte != 8'h00) && !rx_nz_q;

  always_comb begin
    letter = 3'd0;
    case (rx_byte)
      8'h46, 8'h66: letter = 3'd1;
      8'h50, 8'h70: letter = 3'd2;
      8'h43, 8'h63: letter = 3'd3;
      8'h53, 8'h73: letter = 3'd4;
      8'h57, 8'h77: letter = 3'd5;
      default:      letter = 3'd0;
    endcase
  end

  assign is_letter = (letter != 3'd0);
  assign is_term   = (rx_byte == 8'h0D) || (rx_byte == 8'h0A);
  assign is_cancel = (rx_byte == 8'h08) || (rx_byte == 8'h7F);
  assign is_space  = (rx_byte == 8'h20);

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ev) begin
          if (is_letter) begin
            code_d  = letter;
            state_d = S_GOT_CMD;
          end else if (!(is_term || is_space || is_cancel)) begin
            err_d = 1'b1;
          end
        end
      end
      S_GOT_CMD: begin
        if (ev) begin
          if (is_letter) begin
            code_d = letter;
          end else if (is_cancel) begin
            code_d  = 3'd0;
            state_d = S_IDLE;
          end else if (is_term) begin
            // Sleep state is sampled only here; later changes cannot retract.
            if (is_sleeping && (code_q != CODE_WAKE)) begin
              err_d   = 1'b1;
              code_d  = 3'd0;
              state_d = S_IDLE;
            end else begin
              state_d = S_EMIT;
            end
          end else begin
            err_d   = 1'b1;
            code_d  = 3'd0;
            state_d = S_IDLE;
          end
        end
      end
      S_EMIT: begin
        if (act_ready) begin
          cnt_d   = CD_LOAD;
          state_d = S_COOLDOWN;
        end
        if (ev && !is_term) err_d = 1'b1;
      end
      S_COOLDOWN: begin
        if (cnt_q <= 24'd1) begin
          cnt_d   = 24'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
        if (ev && !is_term) err_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d    = (state_d == S_EMIT) || (state_d == S_COOLDOWN);
    err_cnt_d = (err_d && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      code_q    <= 3'd0;
      cnt_q     <= 24'd0;
      rx_nz_q   <= 1'b1;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      cnt_q     <= cnt_d;
      rx_nz_q   <= (rx_byte != 8'h00);
      busy_q    <= busy_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign act_valid = (state_q == S_EMIT);
  assign act_code  = act_valid ? code_q : 3'd0;
  assign busy      = busy_q;
  assign err_pulse = err_q;
  assign err_count = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_decoder.sv
// Scoreboard bench for uart_cmd_decoder with COOLDOWN_CYCLES=8.
`default_nettype none

module tb_uart_cmd_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_byte;
  logic       is_sleeping;
  logic       act_ready;
  logic       act_valid;
  logic [2:0] act_code;
  logic       busy;
  logic       err_pulse;
  logic [7:0] err_count;

  uart_cmd_decoder #(.COOLDOWN_CYCLES(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_byte    (rx_byte),
    .is_sleeping(is_sleeping),
    .act_ready  (act_ready),
    .act_valid  (act_valid),
    .act_code   (act_code),
    .busy       (busy),
    .err_pulse  (err_pulse),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [2:0] exp_q[$];
  int exp_err   = 0;
  int exp_pulse = 0;
  int n_pulse   = 0;
  int busy_run  = 0;
  int last_busy = 0;
  int valid_run = 0;
  int last_valid = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard at every handshake, tracks run lengths and pulses.
  initial begin
    logic       prev_valid = 1'b0;
    logic       prev_hs    = 1'b0;
    logic [2:0] prev_code  = 3'd0;
    logic [2:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
        prev_hs    = 1'b0;
        busy_run   = 0;
        valid_run  = 0;
      end else begin
        if (err_pulse) n_pulse++;
        if (busy) busy_run++;
        else if (busy_run != 0) begin last_busy = busy_run; busy_run = 0; end
        if (act_valid) valid_run++;
        else if (valid_run != 0) begin last_valid = valid_run; valid_run = 0; end
        if (act_valid && prev_valid && !prev_hs)
          check("code_stable", int'(act_code), int'(prev_code));
        if (act_valid && act_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_action: got code %0d expected none", act_code);
          end else begin
            e = exp_q.pop_front();
            check("act_code", int'(act_code), int'(e));
          end
        end
        prev_valid = act_valid;
        prev_hs    = act_valid && act_ready;
        prev_code  = act_code;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_byte = b;
    @(posedge clk); #1;
    rx_byte = 8'h00;
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(input string name);
    for (int k = 0; k < 50 && !act_valid; k++) begin
      @(posedge clk); #1;
    end
    if (!act_valid) check({name, "_valid_timeout"}, 0, 1);
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 100 && busy; k++) begin
      @(posedge clk); #1;
    end
    if (busy) check({name, "_idle_timeout"}, 1, 0);
    repeat (2) begin @(posedge clk); #1; end
    check({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rx_byte = 8'h00; is_sleeping = 1'b0; act_ready = 1'b1;
    #1;
    check("rst_act_valid", int'(act_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_err_count", int'(err_count), 0);
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 'f' CR with immediate ready: one-cycle action, 9 busy cycles
    send_byte("f"); exp_q.push_back(3'd1); send_byte(8'h0D);
    wait_idle("t1");
    check("t1_valid_len", last_valid, 1);
    check("t1_busy_len", last_busy, 9);
    check("t1_err_count", int'(err_count), 0);

    // 'p' 'c' LF with ready low 5 cycles; extra LF during EMIT is silent
    act_ready = 1'b0;
    send_byte("p"); send_byte("c"); exp_q.push_back(3'd3); send_byte(8'h0A);
    wait_valid("t2");
    send_byte(8'h0A);
    repeat (2) begin @(posedge clk); #1; end
    act_ready = 1'b1;
    wait_idle("t2");
    check("t2_valid_len", last_valid, 6);
    check("t2_err_count", int'(err_count), 0);

    // asleep: 's' rejected, 'w' accepted
    is_sleeping = 1'b1;
    send_byte("s"); send_byte(8'h0D);
    exp_err++; exp_pulse++;
    check("t3_err_sleep", int'(err_count), exp_err);
    send_byte("w"); exp_q.push_back(3'd5); send_byte(8'h0D);
    wait_idle("t3");
    is_sleeping = 1'b0;

    // other byte, cancel, and command during cooldown
    send_byte("x"); exp_err++; exp_pulse++;
    check("t4_err_other", int'(err_count), exp_err);
    send_byte("f"); send_byte(8'h08); send_byte(8'h0D);
    repeat (3) begin @(posedge clk); #1; end
    check("t4_err_cancel", int'(err_count), exp_err);
    send_byte("F"); exp_q.push_back(3'd1); send_byte(8'h0D);
    send_byte("f"); exp_err++; exp_pulse++;
    wait_idle("t4");
    check("t4_err_cooldown", int'(err_count), exp_err);

    // saturation
    for (int i = 0; i < 300; i++) begin
      send_byte("x");
      exp_pulse++;
      if (exp_err < 255) exp_err++;
    end
    check("t5_err_sat", int'(err_count), exp_err);
    check("t5_pulses", n_pulse, exp_pulse);

    // reset mid-EMIT with 'f' held through release
    act_ready = 1'b0;
    send_byte("c"); exp_q.push_back(3'd3); send_byte(8'h0D);
    wait_valid("t6");
    rx_byte = "f";
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    exp_err = 0;
    #2;
    check("t6_rst_valid", int'(act_valid), 0);
    check("t6_rst_code", int'(act_code), 0);
    check("t6_rst_busy", int'(busy), 0);
    check("t6_rst_err_pulse", int'(err_pulse), 0);
    check("t6_rst_err_count", int'(err_count), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    act_ready = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    rx_byte = 8'h00;
    @(posedge clk); #1;
    send_byte(8'h0D);
    repeat (3) begin @(posedge clk); #1; end
    check("t6_no_event_busy", int'(busy), 0);
    check("t6_no_event_err", int'(err_count), 0);
    send_byte("f"); exp_q.push_back(3'd1); send_byte(8'h0D);
    wait_idle("t6");
    check("t6_err_final", int'(err_count), exp_err);
    check("final_pulses", n_pulse, exp_pulse);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
